// File: rtl/ysyx_22040931_if_stage_pkg.sv
// rtl/ysyx_22040931_if_stage_pkg.sv - shared reset PC, fetch FSM states and jump-type codes
package ysyx_22040931_if_stage_pkg;

   localparam logic [63:0] ysyx_22040931_RESET_PC = 64'h8000_0000;

   // Jump-type codes as produced by decode
   localparam logic [1:0] ysyx_22040931_JT_NONE = 2'b00;
   localparam logic [1:0] ysyx_22040931_JT_B    = 2'b01;
   localparam logic [1:0] ysyx_22040931_JT_JAL  = 2'b10;
   localparam logic [1:0] ysyx_22040931_JT_JALR = 2'b11;

   typedef enum logic [1:0] {
      ysyx_22040931_IF_IDLE = 2'd0,
      ysyx_22040931_IF_WAIT = 2'd1,
      ysyx_22040931_IF_DROP = 2'd2
   } if_state_t;

endpackage

// File: rtl/ysyx_22040931_if_stage_bpu.sv
// rtl/ysyx_22040931_if_stage_bpu.sv - direct-mapped BTB with 2-bit counters, one lookup and one update port
module ysyx_22040931_BPU
   import ysyx_22040931_if_stage_pkg::*;
#(
   parameter int PC_W  = 64,
   parameter int IDX_W = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [PC_W-1:0] lookup_pc,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target,
   input  logic            upd_en,
   input  logic [PC_W-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_target
);

   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam int DEPTH = 1 << IDX_W;

   logic [DEPTH-1:0] valid;
   logic [1:0]       ctr    [DEPTH];
   logic [TAG_W-1:0] tag    [DEPTH];
   logic [PC_W-1:0]  target [DEPTH];

   logic [IDX_W-1:0] l_idx;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] l_tag;
   logic [TAG_W-1:0] u_tag;
   logic             upd_hit;
   logic             unused_low;

   assign l_idx      = lookup_pc[IDX_W+1:2];
   assign l_tag      = lookup_pc[PC_W-1:IDX_W+2];
   assign u_idx      = upd_pc[IDX_W+1:2];
   assign u_tag      = upd_pc[PC_W-1:IDX_W+2];
   assign unused_low = ^{lookup_pc[1:0], upd_pc[1:0]};

   assign pred_taken  = valid[l_idx] && (tag[l_idx] == l_tag) && ctr[l_idx][1];
   assign pred_target = target[l_idx];
   assign upd_hit     = valid[u_idx] && (tag[u_idx] == u_tag);

   // Lookup is combinational off the old array, so a same-index update is seen next cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid[i]  <= 1'b0;
            ctr[i]    <= 2'b00;
            tag[i]    <= '0;
            target[i] <= '0;
         end
      end else if (upd_en) begin
         if (upd_hit) begin
            if (upd_taken) begin
               if (ctr[u_idx] != 2'b11) ctr[u_idx] <= ctr[u_idx] + 2'd1;
               target[u_idx] <= upd_target;
            end else if (ctr[u_idx] != 2'b00) begin
               ctr[u_idx] <= ctr[u_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            valid[u_idx]  <= 1'b1;
            ctr[u_idx]    <= 2'b10;
            tag[u_idx]    <= u_tag;
            target[u_idx] <= upd_target;
         end
      end
   end

endmodule

// File: rtl/ysyx_22040931_if_stage.sv
// rtl/ysyx_22040931_if_stage.sv - fetch stage: PC, one-outstanding imem fetch, skid buffer, BTB under YSYX_22040931_BPU_EN
module ysyx_22040931_if_stage
   import ysyx_22040931_if_stage_pkg::*;
#(
   parameter int              PC_W      = 64,
   parameter int              INST_W    = 32,
   parameter int              BTB_IDX_W = 4,
   parameter logic [PC_W-1:0] RESET_PC  = PC_W'(ysyx_22040931_RESET_PC)
) (
   input  logic              clock,
   input  logic              reset,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              load_stall,
   input  logic              id_valid,
   input  logic [PC_W-1:0]   id_pc,
   input  logic              id_error_pre,
   input  logic              id_mux_pc,
   input  logic [PC_W-1:0]   id_branch,
   input  logic [1:0]        id_jumptype,
   output logic              valid_o,
   output logic [PC_W-1:0]   pc_o,
   output logic [INST_W-1:0] instr_o,
   output logic              pre_jump,
   output logic [PC_W-1:0]   pre_branch
);

   if_state_t         state;
   if_state_t         state_nxt;
   logic [PC_W-1:0]   fetch_pc;
   logic [PC_W-1:0]   next_pc;
   logic [PC_W-1:0]   fix_pc;
   logic              redirect;
   logic              issue;
   logic              deliver;
   logic              pred_taken;
   logic [PC_W-1:0]   pred_target;

   logic [PC_W-1:0]   req_pc;
   logic              req_pj;
   logic [PC_W-1:0]   req_pb;

   logic              skid_valid;
   logic [PC_W-1:0]   skid_pc;
   logic [INST_W-1:0] skid_instr;
   logic              skid_pj;
   logic [PC_W-1:0]   skid_pb;

   // Decode operands are stale during a load-use stall, so its verdict waits
   assign redirect = id_valid & ~load_stall & id_error_pre;
   assign fix_pc   = id_mux_pc ? id_branch : id_pc + PC_W'(4);

   // An IDLE cycle that redirects must not fetch the wrong-path fetch_pc
   assign issue     = reset & (state == ysyx_22040931_IF_IDLE) & ~skid_valid & ~redirect;
   assign imem_req  = issue;
   assign imem_addr = fetch_pc;
   assign deliver   = (state == ysyx_22040931_IF_WAIT) & imem_rvalid & ~redirect;
   assign next_pc   = pred_taken ? pred_target : fetch_pc + PC_W'(4);

`ifdef YSYX_22040931_BPU_EN
   logic train;

   assign train = id_valid & ~load_stall & (id_jumptype != ysyx_22040931_JT_NONE);

   ysyx_22040931_BPU #(
      .PC_W  (PC_W),
      .IDX_W (BTB_IDX_W)
   ) u_bpu (
      .clock       (clock),
      .reset       (reset),
      .lookup_pc   (fetch_pc),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .upd_en      (train),
      .upd_pc      (id_pc),
      .upd_taken   (id_mux_pc),
      .upd_target  (id_branch)
   );
`else
   logic unused_train;

   assign pred_taken   = 1'b0;
   assign pred_target  = '0;
   assign unused_train = ^id_jumptype;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ysyx_22040931_IF_IDLE: if (issue) state_nxt = ysyx_22040931_IF_WAIT;
         ysyx_22040931_IF_WAIT: begin
            if (imem_rvalid)   state_nxt = ysyx_22040931_IF_IDLE;
            else if (redirect) state_nxt = ysyx_22040931_IF_DROP;
         end
         ysyx_22040931_IF_DROP: if (imem_rvalid) state_nxt = ysyx_22040931_IF_IDLE;
         default:               state_nxt = ysyx_22040931_IF_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ysyx_22040931_IF_IDLE;
         fetch_pc   <= RESET_PC;
         req_pc     <= '0;
         req_pj     <= 1'b0;
         req_pb     <= '0;
         skid_valid <= 1'b0;
         skid_pc    <= '0;
         skid_instr <= '0;
         skid_pj    <= 1'b0;
         skid_pb    <= '0;
         valid_o    <= 1'b0;
         pc_o       <= '0;
         instr_o    <= '0;
         pre_jump   <= 1'b0;
         pre_branch <= '0;
      end else begin
         state <= state_nxt;

         if (redirect)   fetch_pc <= fix_pc;
         else if (issue) fetch_pc <= next_pc;

         if (issue) begin
            req_pc <= fetch_pc;
            req_pj <= pred_taken;
            req_pb <= pred_taken ? pred_target : '0;
         end

         if (redirect) begin
            valid_o    <= 1'b0;
            skid_valid <= 1'b0;
         end else if (deliver) begin
            if (!valid_o || !load_stall) begin
               valid_o    <= 1'b1;
               pc_o       <= req_pc;
               instr_o    <= imem_rdata;
               pre_jump   <= req_pj;
               pre_branch <= req_pb;
            end else begin
               skid_valid <= 1'b1;
               skid_pc    <= req_pc;
               skid_instr <= imem_rdata;
               skid_pj    <= req_pj;
               skid_pb    <= req_pb;
            end
         end else if (!load_stall) begin
            // No fetch is outstanding while the skid holds a word, so drain never races delivery
            if (skid_valid) begin
               valid_o    <= 1'b1;
               pc_o       <= skid_pc;
               instr_o    <= skid_instr;
               pre_jump   <= skid_pj;
               pre_branch <= skid_pb;
               skid_valid <= 1'b0;
            end else begin
               valid_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ysyx_22040931_if_stage.sv
// tb/tb_ysyx_22040931_if_stage.sv - directed bench for the fetch stage with a small imem model
module tb_ysyx_22040931_if_stage;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        load_stall;
   logic        id_valid;
   logic [63:0] id_pc;
   logic        id_error_pre;
   logic        id_mux_pc;
   logic [63:0] id_branch;
   logic [1:0]  id_jumptype;
   logic        valid_o;
   logic [63:0] pc_o;
   logic [31:0] instr_o;
   logic        pre_jump;
   logic [63:0] pre_branch;

   int          vectors;
   int          miscompares;

   logic        pend_v;
   logic [63:0] pend_a;
   int          pend_c;
   int          mem_extra;

   ysyx_22040931_if_stage dut (
      .clock        (clock),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .load_stall   (load_stall),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_error_pre (id_error_pre),
      .id_mux_pc    (id_mux_pc),
      .id_branch    (id_branch),
      .id_jumptype  (id_jumptype),
      .valid_o      (valid_o),
      .pc_o         (pc_o),
      .instr_o      (instr_o),
      .pre_jump     (pre_jump),
      .pre_branch   (pre_branch)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Memory returns addr[31:0]^0x13, mem_extra cycles later than the minimum
   task automatic tick();
      logic        req;
      logic [63:0] a;
      #1;
      req = imem_req;
      a   = imem_addr;
      @(negedge clock);
      imem_rvalid = 1'b0;
      if (req) begin
         pend_v = 1'b1;
         pend_a = a;
         pend_c = mem_extra;
      end
      if (pend_v) begin
         if (pend_c == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_a[31:0] ^ 32'h13;
            pend_v      = 1'b0;
         end else begin
            pend_c--;
         end
      end
      #1;
   endtask

   task automatic assert_reset();
      @(negedge clock);
      reset        = 1'b0;
      load_stall   = 1'b0;
      id_valid     = 1'b0;
      id_pc        = '0;
      id_error_pre = 1'b0;
      id_mux_pc    = 1'b0;
      id_branch    = '0;
      id_jumptype  = 2'b00;
      imem_rvalid  = 1'b0;
      imem_rdata   = '0;
      pend_v       = 1'b0;
      pend_a       = '0;
      pend_c       = 0;
      mem_extra    = 0;
      @(negedge clock);
      @(negedge clock);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      assert_reset();
      vectors++;
      if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %0b want 0", imem_req); end
      vectors++;
      if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b want 0", valid_o); end
      vectors++;
      if (pc_o !== 64'h0) begin miscompares++; $display("FAIL rst_pc: got %h want 0", pc_o); end
      vectors++;
      if (instr_o !== 32'h0) begin miscompares++; $display("FAIL rst_instr: got %h want 0", instr_o); end
      vectors++;
      if (pre_jump !== 1'b0 || pre_branch !== 64'h0) begin
         miscompares++; $display("FAIL rst_pre: got %0b/%h want 0/0", pre_jump, pre_branch);
      end
      release_reset();
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0000) begin
         miscompares++; $display("FAIL rst_first_req: got %0b/%h want 1/80000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_basic();
      assert_reset();
      release_reset();
      tick();
      vectors++;
      if (imem_req !== 1'b0 || valid_o !== 1'b0) begin
         miscompares++; $display("FAIL basic_wait: got req %0b valid %0b want 0 0", imem_req, valid_o);
      end
      tick();
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== 64'h8000_0000 || instr_o !== 32'h8000_0013) begin
         miscompares++; $display("FAIL basic_first: got %0b %h %h want 1 80000000 80000013", valid_o, pc_o, instr_o);
      end
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0004) begin
         miscompares++; $display("FAIL basic_next_req: got %0b/%h want 1/80000004", imem_req, imem_addr);
      end
      tick();
      vectors++;
      if (valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_bubble: got %0b want 0", valid_o); end
      tick();
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== 64'h8000_0004 || instr_o !== 32'h8000_0017) begin
         miscompares++; $display("FAIL basic_second: got %0b %h %h want 1 80000004 80000017", valid_o, pc_o, instr_o);
      end
   endtask

   task automatic test_skid();
      assert_reset();
      release_reset();
      tick();
      tick();
      load_stall = 1'b1;
      tick();
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== 64'h8000_0000) begin
         miscompares++; $display("FAIL skid_hold1: got %0b %h want 1 80000000", valid_o, pc_o);
      end
      tick();
      vectors++;
      if (pc_o !== 64'h8000_0000 || imem_req !== 1'b0) begin
         miscompares++; $display("FAIL skid_hold2: got pc %h req %0b want 80000000 0", pc_o, imem_req);
      end
      tick();
      vectors++;
      if (pc_o !== 64'h8000_0000 || instr_o !== 32'h8000_0013) begin
         miscompares++; $display("FAIL skid_hold3: got %h %h want 80000000 80000013", pc_o, instr_o);
      end
      load_stall = 1'b0;
      tick();
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== 64'h8000_0004 || instr_o !== 32'h8000_0017) begin
         miscompares++; $display("FAIL skid_drain: got %0b %h %h want 1 80000004 80000017", valid_o, pc_o, instr_o);
      end
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0008) begin
         miscompares++; $display("FAIL skid_next_req: got %0b/%h want 1/80000008", imem_req, imem_addr);
      end
      tick();
      vectors++;
      if (valid_o !== 1'b0) begin miscompares++; $display("FAIL skid_no_dup: got %0b want 0", valid_o); end
      tick();
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== 64'h8000_0008 || instr_o !== 32'h8000_001b) begin
         miscompares++; $display("FAIL skid_third: got %0b %h %h want 1 80000008 8000001b", valid_o, pc_o, instr_o);
      end
   endtask

   task automatic test_redirect_wait();
      assert_reset();
      release_reset();
      mem_extra = 1;
      tick();
      id_valid     = 1'b1;
      id_error_pre = 1'b1;
      id_pc        = 64'h8000_0010;
      id_mux_pc    = 1'b1;
      id_branch    = 64'h8000_0100;
      tick();
      id_valid     = 1'b0;
      id_error_pre = 1'b0;
      mem_extra    = 0;
      #1;
      vectors++;
      if (imem_req !== 1'b0 || valid_o !== 1'b0) begin
         miscompares++; $display("FAIL redir_drop: got req %0b valid %0b want 0 0", imem_req, valid_o);
      end
      tick();
      vectors++;
      if (valid_o !== 1'b0) begin miscompares++; $display("FAIL redir_discard: got %0b want 0", valid_o); end
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0100) begin
         miscompares++; $display("FAIL redir_req: got %0b/%h want 1/80000100", imem_req, imem_addr);
      end
      tick();
      tick();
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== 64'h8000_0100 || instr_o !== 32'h8000_0113) begin
         miscompares++; $display("FAIL redir_target: got %0b %h %h want 1 80000100 80000113", valid_o, pc_o, instr_o);
      end
   endtask

   task automatic test_stall_redirect();
      assert_reset();
      release_reset();
      load_stall   = 1'b1;
      id_valid     = 1'b1;
      id_error_pre = 1'b1;
      id_pc        = 64'h8000_0040;
      id_mux_pc    = 1'b0;
      #1;
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0000) begin
         miscompares++; $display("FAIL stredir_blocked0: got %0b/%h want 1/80000000", imem_req, imem_addr);
      end
      tick();
      tick();
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0004 || pc_o !== 64'h8000_0000) begin
         miscompares++; $display("FAIL stredir_blocked1: got %0b/%h pc %h want 1/80000004 80000000", imem_req, imem_addr, pc_o);
      end
      load_stall = 1'b0;
      #1;
      vectors++;
      if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stredir_suppress: got %0b want 0", imem_req); end
      tick();
      id_valid     = 1'b0;
      id_error_pre = 1'b0;
      #1;
      vectors++;
      if (valid_o !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h8000_0044) begin
         miscompares++; $display("FAIL stredir_taken: got %0b %0b/%h want 0 1/80000044", valid_o, imem_req, imem_addr);
      end
   endtask

   task automatic test_no_train_in_stall();
      assert_reset();
      release_reset();
      load_stall  = 1'b1;
      id_valid    = 1'b1;
      id_jumptype = 2'b01;
      id_pc       = 64'h8000_0004;
      id_mux_pc   = 1'b1;
      id_branch   = 64'h8000_0300;
      tick();
      tick();
      load_stall  = 1'b0;
      id_valid    = 1'b0;
      id_jumptype = 2'b00;
      tick();
      tick();
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== 64'h8000_0004 || pre_jump !== 1'b0) begin
         miscompares++; $display("FAIL notrain_pred: got %0b %h pj %0b want 1 80000004 0", valid_o, pc_o, pre_jump);
      end
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0008) begin
         miscompares++; $display("FAIL notrain_next: got %0b/%h want 1/80000008", imem_req, imem_addr);
      end
   endtask

   task automatic test_btb();
      logic        exp_pj;
      logic [63:0] exp_pb;
      logic [63:0] exp_next;
      bit          found;
`ifdef YSYX_22040931_BPU_EN
      exp_pj   = 1'b1;
      exp_pb   = 64'h8000_0080;
      exp_next = 64'h8000_0080;
`else
      exp_pj   = 1'b0;
      exp_pb   = 64'h0;
      exp_next = 64'h8000_0024;
`endif
      assert_reset();
      release_reset();
      id_valid    = 1'b1;
      id_jumptype = 2'b01;
      id_pc       = 64'h8000_0020;
      id_mux_pc   = 1'b1;
      id_branch   = 64'h8000_0080;
      tick();
      tick();
      id_valid    = 1'b0;
      id_jumptype = 2'b00;
      #1;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (imem_req === 1'b1 && imem_addr === 64'h8000_0020) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      vectors++;
      if (!found) begin
         miscompares++; $display("FAIL btb_reach: got no fetch of 80000020 within 40 cycles");
      end else begin
         tick();
         tick();
         vectors++;
         if (valid_o !== 1'b1 || pc_o !== 64'h8000_0020 || pre_jump !== exp_pj || pre_branch !== exp_pb) begin
            miscompares++;
            $display("FAIL btb_pred: got %0b %h pj %0b pb %h want 1 80000020 %0b %h", valid_o, pc_o, pre_jump, pre_branch, exp_pj, exp_pb);
         end
         vectors++;
         if (imem_req !== 1'b1 || imem_addr !== exp_next) begin
            miscompares++; $display("FAIL btb_next: got %0b/%h want 1/%h", imem_req, imem_addr, exp_next);
         end
      end
   endtask

   task automatic test_async_reset();
      assert_reset();
      release_reset();
      tick();
      tick();
      mem_extra = 2;
      tick();
      vectors++;
      if (pc_o !== 64'h8000_0000) begin miscompares++; $display("FAIL areset_pre: got %h want 80000000", pc_o); end
      #2;
      reset = 1'b0;
      #1;
      vectors++;
      if (imem_req !== 1'b0 || valid_o !== 1'b0 || pc_o !== 64'h0 || instr_o !== 32'h0) begin
         miscompares++; $display("FAIL areset_clear: got %0b %0b %h %h want 0 0 0 0", imem_req, valid_o, pc_o, instr_o);
      end
      @(negedge clock);
      pend_v      = 1'b0;
      mem_extra   = 0;
      reset       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hdead_beef;
      #1;
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h8000_0000) begin
         miscompares++; $display("FAIL areset_restart: got %0b/%h want 1/80000000", imem_req, imem_addr);
      end
      tick();
      vectors++;
      if (valid_o !== 1'b0) begin miscompares++; $display("FAIL areset_stray: got %0b want 0", valid_o); end
      tick();
      vectors++;
      if (valid_o !== 1'b1 || pc_o !== 64'h8000_0000 || instr_o !== 32'h8000_0013) begin
         miscompares++; $display("FAIL areset_first: got %0b %h %h want 1 80000000 80000013", valid_o, pc_o, instr_o);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b0;
      load_stall   = 1'b0;
      id_valid     = 1'b0;
      id_pc        = '0;
      id_error_pre = 1'b0;
      id_mux_pc    = 1'b0;
      id_branch    = '0;
      id_jumptype  = 2'b00;
      imem_rvalid  = 1'b0;
      imem_rdata   = '0;
      pend_v       = 1'b0;
      pend_a       = '0;
      pend_c       = 0;
      mem_extra    = 0;
      test_reset();
      test_basic();
      test_skid();
      test_redirect_wait();
      test_stall_redirect();
      test_no_train_in_stall();
      test_btb();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
